// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default sizing for the memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned ADDR_WIDTH_DEF   = 9;
  localparam int unsigned MEM_SIZE_DEF     = 512;
  localparam int unsigned CNT_WIDTH        = 4;
  localparam int unsigned WAIT_STATES_MAX  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the RAM strobe; zero_c flags the final ACCESS cycle.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 zero_c
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-RAM transfer sequencer: IDLE -> ACCESS (WAIT_STATES+1 strobe cycles) -> DONE.
// Optional address bound check enabled by defining MEM_ACCESS_BOUND_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_SIZE      = MEM_SIZE_DEF,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic                     Clock,
  input  logic                     Clear_n,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     ram_read,
  output logic                     ram_write,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WAIT_STATES);

  if (WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..15");
  end
  if (MEM_SIZE > (64'd1 << ADDRESS_WIDTH)) begin : g_bad_mem_size
    $error("MEM_SIZE exceeds the address space");
  end

  state_t state, state_next;
  logic   op_write_q, op_write_next;
  logic   one_req, both_req, out_of_range, accept_c, reject_c;
  logic   cnt_zero_c, cnt_load, cnt_dec, capture;
  logic   busy_d, done_d, err_d, ram_read_d, ram_write_d;

  assign one_req  = req_read ^ req_write;
  assign both_req = req_read & req_write;

`ifdef MEM_ACCESS_BOUND_CHECK_EN
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);
  assign out_of_range = one_req & ({1'b0, req_addr} >= MEM_LIMIT);
`else
  assign out_of_range = 1'b0;
`endif

  assign accept_c = (state == IDLE) & one_req & ~out_of_range;
  assign reject_c = (state == IDLE) & (both_req | out_of_range);

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept_c)   state_next = ACCESS;
      ACCESS:  if (cnt_zero_c) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    busy_d        = 1'b0;
    done_d        = 1'b0;
    err_d         = reject_c;
    ram_read_d    = 1'b0;
    ram_write_d   = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    capture       = 1'b0;
    op_write_next = op_write_q;
    if (accept_c) begin
      op_write_next = req_write;
      cnt_load      = 1'b1;
    end
    unique case (state_next)
      ACCESS: begin
        busy_d      = 1'b1;
        ram_read_d  = ~op_write_next;
        ram_write_d = op_write_next;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
    if (state == ACCESS) begin
      cnt_dec = ~cnt_zero_c;
      capture = cnt_zero_c & ~op_write_q;
    end
  end

  // Address and write data only change on acceptance, so RAM inputs stay stable mid-write.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      op_write_q  <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rdata       <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      ram_read   <= ram_read_d;
      ram_write  <= ram_write_d;
      op_write_q <= op_write_next;
      if (accept_c) begin
        ram_address <= req_addr;
        ram_data_in <= req_wdata;
      end
      if (capture) rdata <= ram_data_out;
    end
  end

  mem_wait_counter u_wait_counter (
    .clk        (Clock),
    .rst_n      (Clear_n),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (CNT_LOAD),
    .zero_c     (cnt_zero_c)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl: one WAIT_STATES=1/MEM_SIZE=256 instance
// and one WAIT_STATES=0/MEM_SIZE=512 instance sharing a RAM model and request bus.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        Clear_n = 1'b1;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  bit          sel = 1'b1;

  logic        d1_busy, d1_done, d1_err, d1_rread, d1_rwrite;
  logic [31:0] d1_rdata, d1_wdata, d1_dout;
  logic [8:0]  d1_addr;
  logic        d0_busy, d0_done, d0_err, d0_rread, d0_rwrite;
  logic [31:0] d0_rdata, d0_wdata, d0_dout;
  logic [8:0]  d0_addr;

  logic [31:0] ram   [512];
  bit          ram_v [512];
  logic [31:0] mem_model [512];
  logic [31:0] exp_rdata [2];
  logic [31:0] exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [8:0] a);
    return 32'h1000_0000 | 32'(a);
  endfunction

  assign d1_dout = ram_v[d1_addr] ? ram[d1_addr] : pat(d1_addr);
  assign d0_dout = ram_v[d0_addr] ? ram[d0_addr] : pat(d0_addr);

  always @(negedge clk) begin
    if (d1_rwrite) begin ram[d1_addr] <= d1_wdata; ram_v[d1_addr] <= 1'b1; end
    if (d0_rwrite) begin ram[d0_addr] <= d0_wdata; ram_v[d0_addr] <= 1'b1; end
  end

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(256), .WAIT_STATES(1)) dut (
    .Clock(clk), .Clear_n(Clear_n),
    .req_read(req_read & sel), .req_write(req_write & sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(d1_busy), .done(d1_done), .err(d1_err), .rdata(d1_rdata),
    .ram_read(d1_rread), .ram_write(d1_rwrite), .ram_address(d1_addr),
    .ram_data_in(d1_wdata), .ram_data_out(d1_dout)
  );

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9), .MEM_SIZE(512), .WAIT_STATES(0)) dut_ws0 (
    .Clock(clk), .Clear_n(Clear_n),
    .req_read(req_read & ~sel), .req_write(req_write & ~sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(d0_busy), .done(d0_done), .err(d0_err), .rdata(d0_rdata),
    .ram_read(d0_rread), .ram_write(d0_rwrite), .ram_address(d0_addr),
    .ram_data_in(d0_wdata), .ram_data_out(d0_dout)
  );

  wire        s_busy   = sel ? d1_busy   : d0_busy;
  wire        s_done   = sel ? d1_done   : d0_done;
  wire        s_err    = sel ? d1_err    : d0_err;
  wire        s_rread  = sel ? d1_rread  : d0_rread;
  wire        s_rwrite = sel ? d1_rwrite : d0_rwrite;
  wire [31:0] s_rdata  = sel ? d1_rdata  : d0_rdata;
  wire [31:0] s_wdata  = sel ? d1_wdata  : d0_wdata;
  wire [8:0]  s_addr   = sel ? d1_addr   : d0_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepted transfer: checks strobes, latency and the scoreboarded rdata at the done pulse.
  task automatic xfer(input bit wr, input logic [8:0] a, input logic [31:0] d);
    int n, strobes, ws;
    bit seen;
    ws = sel ? 1 : 0;
    @(negedge clk);
    req_read = ~wr; req_write = wr; req_addr = a; req_wdata = d;
    if (wr) mem_model[a] = d;
    else    exp_rdata[sel] = mem_model[a];
    exp_q.push_back(exp_rdata[sel]);
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    check("busy_on_accept", 32'(s_busy), 32'd1);
    check("ram_address", 32'(s_addr), 32'(a));
    if (wr) check("ram_data_in", s_wdata, d);
    n = 0; strobes = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (wr ? s_rwrite : s_rread) strobes++;
      check("wrong_strobe", 32'(wr ? s_rread : s_rwrite), 32'd0);
      seen = s_done;
    end
    check("done_latency", 32'(n), 32'(ws + 2));
    check("strobe_cycles", 32'(strobes), 32'(ws + 1));
    if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check("rdata", s_rdata, exp_q.pop_front());
  endtask

  task automatic reject(input logic rd, input logic wr, input logic [8:0] a);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(s_err), 32'd1);
    check("busy_on_err", 32'(s_busy), 32'd0);
    check("strobe_on_err", 32'({s_rread, s_rwrite}), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(s_err), 32'd0);
    check("busy_after_err", 32'(s_busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({s_busy, s_done, s_err, s_rread, s_rwrite}), 32'd0);
    check({tag, "_rdata"}, s_rdata, 32'd0);
    check({tag, "_addr"}, 32'(s_addr), 32'd0);
    check({tag, "_wdata"}, s_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem_model[i] = pat(9'(i));
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    #2 Clear_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b1; check_all_zero("reset_ws1");
    sel = 1'b0; check_all_zero("reset_ws0");
    Clear_n = 1'b1;
    sel = 1'b1;

    xfer(1'b1, 9'd5, 32'hDEAD_BEEF);
    xfer(1'b0, 9'd5, '0);
    reject(1'b1, 1'b1, 9'd7);

    // Abort a read during its second ACCESS cycle.
    @(negedge clk);
    req_read = 1'b1; req_addr = 9'd5;
    @(posedge clk); #1;
    req_read = 1'b0;
    check("rread_before_abort", 32'(s_rread), 32'd1);
    @(posedge clk); #2;
    Clear_n = 1'b0;
    #1;
    check_all_zero("async_abort");
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) begin
      @(negedge clk);
      check("no_done_in_reset", 32'({s_done, s_busy}), 32'd0);
    end
    Clear_n = 1'b1;
    xfer(1'b0, 9'd5, '0);

    xfer(1'b0, 9'd1, '0);
    xfer(1'b0, 9'd2, '0);
    xfer(1'b1, 9'd255, 32'hCAFE_F00D);
    xfer(1'b0, 9'd255, '0);
`ifdef MEM_ACCESS_BOUND_CHECK_EN
    reject(1'b0, 1'b1, 9'd300);
    reject(1'b1, 1'b0, 9'd300);
`else
    xfer(1'b0, 9'd300, '0);
`endif
    xfer(1'b0, 9'd1, '0);

    sel = 1'b0;
    xfer(1'b1, 9'd511, 32'h0000_0001);
    xfer(1'b0, 9'd511, '0);
    reject(1'b1, 1'b1, 9'd511);
    xfer(1'b0, 9'd5, '0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
